// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: result = r1 - r2 - bi, one bit per clock, LSB first.
// Optional signed-overflow output `ovf` is compiled in when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] r1,
  input  logic [W-1:0] r2,
  input  logic         bi,
  output logic [W-1:0] result,
  output logic         borrow,
  output logic         busy,
  output logic         done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CNT_W = (W > 2) ? $clog2(W) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // One full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] sub_cell(input logic x, input logic y, input logic bin);
    sub_cell = {(~x & y) | (~(x ^ y) & bin), x ^ y ^ bin};
  endfunction

  logic [1:0]       state_r;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [W-1:0]     res_r;
  logic             br_r;
  logic [CNT_W-1:0] cnt_r;
  logic             borrow_r;
  logic             busy_r;
  logic             done_r;
  logic [1:0]       cell_s;
  logic             last_s;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_r;
`endif

  // Shared subtractor cell and final-bit detect.
  always_comb begin
    cell_s = sub_cell(a_r[0], b_r[0], br_r);
    last_s = (cnt_r == CNT_LAST);
  end

  // Control FSM and datapath shift registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      res_r    <= '0;
      br_r     <= 1'b0;
      cnt_r    <= '0;
      borrow_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r      <= r1;
            b_r      <= r2;
            br_r     <= bi;
            cnt_r    <= '0;
            res_r    <= '0;
            borrow_r <= 1'b0;
            busy_r   <= 1'b1;
            state_r  <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            ovf_r    <= 1'b0;
`endif
          end
        end
        RUN: begin
          a_r   <= {1'b0, a_r[W-1:1]};
          b_r   <= {1'b0, b_r[W-1:1]};
          br_r  <= cell_s[1];
          res_r <= {cell_s[0], res_r[W-1:1]};
          cnt_r <= cnt_r + CNT_ONE;
          if (last_s) begin
            state_r  <= DONE;
            done_r   <= 1'b1;
            borrow_r <= cell_s[1];
`ifdef SERIAL_SUB_OVF_EN
            // Overflow: borrow into the sign bit differs from borrow out of it.
            ovf_r    <= br_r ^ cell_s[1];
`endif
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign result = res_r;
  assign borrow = borrow_r;
  assign busy   = busy_r;
  assign done   = done_r;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf    = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (W=4): directed table, corner sequences, random ops.
module tb_serial_subtractor;
  localparam int W = 4;
  localparam int MASK = (1 << W) - 1;
  localparam int BOUND = 20;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] r1;
  logic [W-1:0] r2;
  logic         bi;
  logic [W-1:0] result;
  logic         borrow;
  logic         busy;
  logic         done;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad = 0;

  serial_subtractor #(.W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .r1(r1), .r2(r2), .bi(bi),
    .result(result), .borrow(borrow), .busy(busy), .done(done)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int r1;
    int r2;
    int bi;
    int res;
    int brw;
    int ov;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  task automatic ref_model(input int a, input int b, input int c,
                           output int res, output int brw, output int ov);
    int sa, sb, sd;
    res = (a - b - c) & MASK;
    brw = (a < b + c) ? 1 : 0;
    sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    sd = sa - sb - c;
    ov = (sd < -(1 << (W - 1)) || sd > (1 << (W - 1)) - 1) ? 1 : 0;
  endtask

  function automatic int get_ovf();
`ifdef SERIAL_SUB_OVF_EN
    return int'(ovf);
`else
    return 0;
`endif
  endfunction

  // Wait for done (bounded); k counts edges already seen since the accepting edge.
  task automatic wait_done(input int k0, output int lat);
    lat = -1;
    for (int k = k0 + 1; k <= BOUND; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      check("busy_during_run", int'(busy), 1);
    end
  endtask

  // Launch one operation and return what the DUT reports at done.
  task automatic run_op(input int a, input int b, input int c,
                        output int res, output int brw, output int ov, output int lat);
    @(negedge clk);
    r1 = a[W-1:0]; r2 = b[W-1:0]; bi = c[0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    r1 = W'($urandom); r2 = W'($urandom); bi = 1'($urandom);
    check("busy_after_accept", int'(busy), 1);
    wait_done(0, lat);
    res = int'(result); brw = int'(borrow); ov = get_ovf();
    @(posedge clk); #1;
    check("done_falls", int'(done), 0);
    check("busy_falls", int'(busy), 0);
    check("result_holds", int'(result), res);
  endtask

  initial begin
    int res, brw, ov, lat, e_res, e_brw, e_ov, gap, seen;

    vecs[0] = '{7, 3, 0, 4, 0, 0};
    vecs[1] = '{3, 7, 0, 12, 1, 0};
    vecs[2] = '{0, 0, 1, 15, 1, 0};
    vecs[3] = '{15, 15, 1, 15, 1, 0};
    vecs[4] = '{8, 1, 0, 7, 0, 1};
    vecs[5] = '{7, 15, 0, 8, 1, 1};

    reset = 1'b1; start = 1'b0; r1 = '0; r2 = '0; bi = 1'b0;
    repeat (2) @(posedge clk);
    // start together with reset must be discarded
    @(negedge clk); start = 1'b1; r1 = 4'd9; r2 = 4'd1;
    @(posedge clk); #1;
    check("reset_result", int'(result), 0);
    check("reset_borrow", int'(borrow), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset_ovf", int'(ovf), 0);
`endif
    @(negedge clk); start = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    check("start_with_reset_ignored", int'(busy), 0);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].r1, vecs[i].r2, vecs[i].bi, res, brw, ov, lat);
      check($sformatf("tbl%0d_latency", i), lat, W);
      check($sformatf("tbl%0d_result", i), res, vecs[i].res);
      check($sformatf("tbl%0d_borrow", i), brw, vecs[i].brw);
`ifdef SERIAL_SUB_OVF_EN
      check($sformatf("tbl%0d_ovf", i), ov, vecs[i].ov);
`endif
    end

    // Start during RUN is ignored; a start on the first IDLE edge is accepted
    @(negedge clk); r1 = 4'd9; r2 = 4'd2; bi = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(negedge clk); r1 = 4'd1; r2 = 4'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(2, lat);
    check("ign_latency", lat, W);
    check("ign_result", int'(result), 7);
    @(negedge clk); r1 = 4'd10; r2 = 4'd4; bi = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    check("ign_done_to_idle", int'(busy), 0);
    @(posedge clk); #1; start = 1'b0;
    check("ign_idle_accept", int'(busy), 1);
    wait_done(0, lat);
    check("ign2_latency", lat, W);
    check("ign2_result", int'(result), 6);
    @(posedge clk); #1;

    // Reset on the 2nd RUN edge aborts without a done pulse
    @(negedge clk); r1 = 4'd9; r2 = 4'd3; bi = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("abort_result", int'(result), 0);
    check("abort_borrow", int'(borrow), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    @(negedge clk); reset = 1'b0;
    seen = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    check("abort_no_done", seen, 0);
    run_op(5, 5, 0, res, brw, ov, lat);
    check("after_abort_result", res, 0);
    check("after_abort_borrow", brw, 0);

    // start held high: back-to-back operations every W+2 cycles
    @(negedge clk); r1 = 4'd6; r2 = 4'd1; bi = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    wait_done(0, lat);
    check("held_first_latency", lat, W);
    gap = -1;
    for (int k = 1; k <= BOUND; k++) begin
      @(posedge clk); #1;
      if (done) begin
        gap = k;
        break;
      end
    end
    check("held_period", gap, W + 2);
    check("held_result", int'(result), 5);
    @(negedge clk); start = 1'b0;
    repeat (W + 3) @(posedge clk);
    #1;
    check("held_idle", int'(busy), 0);

    // Random operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      int a, b, c;
      a = int'($urandom_range(0, MASK));
      b = int'($urandom_range(0, MASK));
      c = int'($urandom_range(0, 1));
      ref_model(a, b, c, e_res, e_brw, e_ov);
      run_op(a, b, c, res, brw, ov, lat);
      check($sformatf("rnd%0d_latency", i), lat, W);
      check($sformatf("rnd%0d_result(%0d-%0d-%0d)", i, a, b, c), res, e_res);
      check($sformatf("rnd%0d_borrow", i), brw, e_brw);
`ifdef SERIAL_SUB_OVF_EN
      check($sformatf("rnd%0d_ovf", i), ov, e_ov);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
